control_splitter: RTL and testbench

Readback serializer for the wave generator's parameter banks: the reader counterpart to the pipe-in combiner that assembles 64 × 16-bit words into a 1024-bit bank. On a snapshot pulse it captures one 1024-bit bank (active amps, offsets or phase words) into a shadow register. It then streams the bank word-by-word to a pipe-out endpoint under the endpoint's read strobe, so the host can verify what the generator is actually running. It sits in the host-clock domain beside the combiners and drives an okPipeOut `ep_datain`.

---
 rtl/control_splitter_pkg.sv | 7 +
 rtl/control_splitter_word_mux.sv | 27 ++
 rtl/control_splitter.sv | 90 +++++++++
 tb/tb_control_splitter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/control_splitter_pkg.sv
// control_splitter_pkg: shared state enum, bank layout defaults and checksum width.
package control_splitter_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 64;
  localparam int CSUM_W        = DEF_WORD_W;
endpackage

// File: rtl/control_splitter_word_mux.sv
// word_mux: registered NUM_WORDS:1 word selector; indices past the bank select the extra word.
module word_mux #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 64,
  parameter int IDX_W     = 7
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [WORD_W*NUM_WORDS-1:0] bank,
  input  logic [IDX_W-1:0]            idx,
  input  logic [WORD_W-1:0]           extra,
  output logic [WORD_W-1:0]           dout
);
  logic [WORD_W-1:0] sel, dout_d, dout_q;
  always_comb begin
    sel = extra;
    for (int k = 0; k < NUM_WORDS; k++)
      if (idx == IDX_W'(k)) sel = bank[k*WORD_W +: WORD_W];
    dout_d = clr ? '0 : en ? sel : dout_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) dout_q <= '0;
    else          dout_q <= dout_d;
  assign dout = dout_q;
endmodule

// File: rtl/control_splitter.sv
// control_splitter: snapshot a parameter bank and stream it word-by-word to a pipe-out port.
// Define CONTROL_SPLITTER_CHECKSUM_EN to append a modulo-2^WORD_W sum trailer word.
module control_splitter
  import control_splitter_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        snapshot,
  input  logic [WORD_W*NUM_WORDS-1:0] combined_in,
  input  logic                        read,
  output logic [WORD_W-1:0]           dataout,
  output logic                        busy,
  output logic [ADDR_W:0]             words_left,
  output logic                        done,
  output logic                        underrun
);
`ifdef CONTROL_SPLITTER_CHECKSUM_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif
  localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(NUM_WORDS + TRAILER);
  state_t                      state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0] shadow_q, shadow_d;
  logic [ADDR_W:0]             idx_q, idx_d, left_q, left_d;
  logic                        busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;
  logic                        rd_ok, last;
  logic [WORD_W-1:0]           extra;
  always_comb begin
    rd_ok      = state_q == STREAM && read && !snapshot;
    last       = left_q == 1;
    state_d    = snapshot ? STREAM : (rd_ok && last) ? DONE : state_q;
    shadow_d   = snapshot ? combined_in : shadow_q;
    idx_d      = snapshot ? '0 : rd_ok ? idx_q + 1 : idx_q;
    left_d     = snapshot ? TOTAL : rd_ok ? left_q - 1 : left_q;
    busy_d     = snapshot || (busy_q && !(rd_ok && last));
    done_d     = rd_ok && last;
    underrun_d = !snapshot && (underrun_q || (read && state_q != STREAM));
  end
`ifdef CONTROL_SPLITTER_CHECKSUM_EN
  // Running sum of consumed words; after the last data word it is exactly the trailer.
  logic [CSUM_W-1:0] sum_q, sum_d;
  always_comb begin
    sum_d = snapshot ? '0 : rd_ok ? sum_q + CSUM_W'(dataout) : sum_q;
    extra = WORD_W'(sum_d);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
`else
  assign extra = '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      left_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      left_q     <= left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  // Snapshot selects from combined_in directly so word 0 appears one cycle later.
  word_mux #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(ADDR_W+1)) u_mux (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (snapshot || rd_ok),
    .clr     (rd_ok && last),
    .bank    (shadow_d),
    .idx     (idx_d),
    .extra   (extra),
    .dout    (dataout)
  );
  assign busy       = busy_q;
  assign words_left = left_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_control_splitter.sv
// tb_control_splitter: table vectors, directed sequences and random stimulus against a queue model.
module tb_control_splitter;
  localparam int W = 16;
  localparam int N = 64;
  localparam int A = 6;
`ifdef CONTROL_SPLITTER_CHECKSUM_EN
  localparam int TR = 1;
`else
  localparam int TR = 0;
`endif
  localparam int TOT = N + TR;

  logic           clk = 0, reset_n = 1, snapshot = 0, read = 0;
  logic [W*N-1:0] combined_in = '0;
  logic [W-1:0]   dataout;
  logic           busy, done, underrun;
  logic [A:0]     words_left;

  control_splitter #(.WORD_W(W), .NUM_WORDS(N), .ADDR_W(A)) dut (
    .clk(clk), .reset_n(reset_n), .snapshot(snapshot), .combined_in(combined_in),
    .read(read), .dataout(dataout), .busy(busy), .words_left(words_left),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         s;
    bit         r;
    logic [15:0] dout;
    int         left;
    bit         busy;
    bit         done;
    bit         und;
  } vec_t;

  int         checks = 0, errors = 0;
  logic [W-1:0] bank[N];
  logic [W-1:0] mq[$];
  bit         m_und = 0;
  vec_t       vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: base+k, 1: all base, 2: random
  task automatic load(input logic [W-1:0] base, input int mode);
    for (int k = 0; k < N; k++) begin
      bank[k] = mode == 0 ? base + W'(k) : mode == 1 ? base : W'($urandom);
      combined_in[k*W +: W] = bank[k];
    end
  endtask

  // Stream = queue of captured words (plus wrapped sum); reads pop, empty reads are underruns.
  task automatic model(input bit s, input bit r, output bit d);
    logic [W-1:0] sum;
    d = 0;
    if (s) begin
      mq.delete();
      sum = '0;
      for (int k = 0; k < N; k++) begin
        mq.push_back(bank[k]);
        sum = sum + bank[k];
      end
      if (TR == 1) mq.push_back(sum);
      m_und = 0;
    end else if (r) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        d = mq.size() == 0;
      end else m_und = 1;
    end
  endtask

  task automatic cyc(input bit s, input bit r);
    snapshot = s;
    read = r;
    @(posedge clk);
    #1;
    snapshot = 0;
    read = 0;
  endtask

  task automatic cmp_model(input string tag, input bit d);
    chk({tag, "_dout"}, dataout, mq.size() > 0 ? mq[0] : 16'h0);
    chk({tag, "_left"}, words_left, mq.size());
    chk({tag, "_busy"}, busy, mq.size() > 0);
    chk({tag, "_done"}, done, d);
    chk({tag, "_underrun"}, underrun, m_und);
  endtask

  task automatic step(input string tag, input bit s, input bit r, output bit d);
    model(s, r, d);
    cyc(s, r);
    cmp_model(tag, d);
  endtask

  initial begin
    bit d;
    int dones;
    bit pat[4];
    pat = '{1, 0, 0, 1};
    vt[0] = '{0, 1, 16'h0000, 0, 0, 0, 1};
    vt[1] = '{0, 1, 16'h0000, 0, 0, 0, 1};
    vt[2] = '{0, 1, 16'h0000, 0, 0, 0, 1};
    vt[3] = '{1, 0, 16'h1000, TOT, 1, 0, 0};
    vt[4] = '{0, 1, 16'h1001, TOT-1, 1, 0, 0};
    vt[5] = '{0, 0, 16'h1001, TOT-1, 1, 0, 0};
    vt[6] = '{0, 0, 16'h1001, TOT-1, 1, 0, 0};
    vt[7] = '{0, 1, 16'h1002, TOT-2, 1, 0, 0};
    vt[8] = '{1, 1, 16'h1000, TOT, 1, 0, 0};
    vt[9] = '{0, 1, 16'h1001, TOT-1, 1, 0, 0};

    load(16'h1000, 0);
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dataout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", words_left, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1;

    for (int i = 0; i < 10; i++) begin
      model(vt[i].s, vt[i].r, d);
      cyc(vt[i].s, vt[i].r);
      chk($sformatf("vec%0d_dout", i), dataout, vt[i].dout);
      chk($sformatf("vec%0d_left", i), words_left, vt[i].left);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_done", i), done, vt[i].done);
      chk($sformatf("vec%0d_underrun", i), underrun, vt[i].und);
    end

    step("full_snap", 1, 0, d);
    dones = 0;
    for (int i = 0; i < TOT; i++) begin
      step("full", 0, 1, d);
      if (i < N - 1) chk("full_word", dataout, 16'h1000 + 32'(i) + 1);
      dones += int'(done);
    end
    chk("full_done_count", dones, 1);
    step("after_full", 0, 0, d);
    step("after_full_read", 0, 1, d);

    step("tog_snap", 1, 0, d);
    for (int i = 0; i < 2 * TOT; i++) step("toggle", 0, pat[i % 4], d);

    step("abort_snap", 1, 0, d);
    for (int i = 0; i < 10; i++) step("abort_rd", 0, 1, d);
    load(16'hA000, 0);
    step("abort", 1, 0, d);
    chk("abort_word0", dataout, 16'hA000);
    chk("abort_left", words_left, TOT);
    chk("abort_nodone", done, 0);
    for (int i = 0; i < 5; i++) step("abort_cont", 0, 1, d);

    load(16'h0401, 1);
    step("csum_snap", 1, 0, d);
    for (int i = 0; i < N; i++) step("csum", 0, 1, d);
`ifdef CONTROL_SPLITTER_CHECKSUM_EN
    chk("csum_trailer", dataout, 16'h0040);
    step("csum_last", 0, 1, d);
    chk("csum_done", done, 1);
`endif

    for (int i = 0; i < 600; i++) begin
      bit s;
      s = $urandom_range(0, 39) == 0;
      if (s) load(16'h0, 2);
      step("rand", s, 1'($urandom_range(0, 1)), d);
    end

    load(16'h5500, 0);
    step("arst_snap", 1, 0, d);
    for (int i = 0; i < 5; i++) step("arst_rd", 0, 1, d);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    mq.delete();
    m_und = 0;
    cmp_model("arst_async", 0);
    @(posedge clk);
    #1 reset_n = 1;
    cmp_model("arst_hold", 0);
    step("arst_read", 0, 1, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
